// File: rtl/game_pkg.sv
// Shared game-level types: object identifiers and object bitmap geometry.
package game_pkg;

    localparam int MAP_H_WIDTH = 5;
    localparam int MAP_V_WIDTH = 5;

    typedef enum logic [2:0] {
        OBJECT_MAP  = 3'd0,
        OBJECT_CAR1 = 3'd1,
        OBJECT_CAR2 = 3'd2,
        OBJECT_CAR3 = 3'd3,
        OBJECT_CAR4 = 3'd4
    } ObjectID;

endpackage

// File: rtl/sram_pkg.sv
// SRAM word layout and read-path timing shared by the address encoder and pixel decoder.
package sram_pkg;

    localparam int SRAM_DATA_W        = 16;
    localparam int PIXELS_PER_WORD    = 4;
    localparam int PIXEL_W            = 4;
    localparam int PIXEL_SUB_W        = 2;
    localparam int TRANSPARENT_IDX    = 0;
    localparam int SRAM_READ_PIPE_LAT = 2;

    typedef struct packed {
        game_pkg::ObjectID        id;
        logic [PIXEL_SUB_W-1:0]   sub;
    } PixelTag;

endpackage

// File: rtl/pixel_fifo.sv
// Generic first-word fall-through FIFO with occupancy count.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: pushes when full are dropped and flagged by assertion; pops when empty are ignored.
module pixel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage is reset so the head reads as all-zero while the block is held in reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    push_not_full: assert property (@(posedge i_clk) disable iff (i_rst) !(push && full));

endmodule

// File: rtl/sram_pixel_decoder.sv
// Tracks pixel requests through the SRAM read latency and extracts the addressed palette nibble.
// Latency: PIPE_LAT+1 cycles from accept to o_pix_valid with an empty FIFO; 1 pixel/cycle throughput.
// Backpressure: credit-based; o_req_ready drops once inflight tags plus FIFO entries reach FIFO_DEPTH.
module sram_pixel_decoder #(
    parameter int PIPE_LAT        = sram_pkg::SRAM_READ_PIPE_LAT,
    parameter int FIFO_DEPTH      = 4,
    parameter int DATA_W          = sram_pkg::SRAM_DATA_W,
    parameter int PIX_W           = sram_pkg::PIXEL_W,
    parameter int TRANSPARENT_IDX = sram_pkg::TRANSPARENT_IDX
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst,
    input  logic                                                  i_req_valid,
    output logic                                                  o_req_ready,
    input  game_pkg::ObjectID                                     i_req_object_id,
    input  logic [game_pkg::MAP_H_WIDTH+game_pkg::MAP_V_WIDTH-1:0] i_req_pixel_index,
    input  logic [DATA_W-1:0]                                     i_sram_rdata,
    output logic                                                  o_pix_valid,
    input  logic                                                  i_pix_ready,
    output logic [PIX_W-1:0]                                      o_pix_index,
    output logic                                                  o_pix_transparent,
    output game_pkg::ObjectID                                     o_pix_object_id
);
    import game_pkg::*;
    import sram_pkg::*;

    localparam int IDX_W = MAP_H_WIDTH + MAP_V_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PIX_W-1:0] index;
        logic             transparent;
        ObjectID          id;
    } pix_entry_t;

    logic [PIPE_LAT-1:0] tag_vld;
    PixelTag             tag_q [PIPE_LAT];
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    occ;
    logic [CNT_W:0]      credit_used;
    logic                accept;
    logic                capture;
    logic                pop;
    logic                fifo_empty;
    PixelTag             cap_tag;
    logic [PIX_W-1:0]    cap_pix;
    pix_entry_t          push_entry;
    pix_entry_t          head;
    logic                unused_idx_bits;

    assign credit_used = {1'b0, inflight} + {1'b0, occ};
    assign o_req_ready = !i_rst && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign accept      = i_req_valid && o_req_ready;

    // Only the sub-word select matters here; the word address came from the encoder.
    assign unused_idx_bits = ^i_req_pixel_index[IDX_W-1:PIXEL_SUB_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_vld[0] <= accept;
            tag_q[0]   <= '{id: i_req_object_id, sub: i_req_pixel_index[PIXEL_SUB_W-1:0]};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign capture = tag_vld[PIPE_LAT-1];
    assign cap_tag = tag_q[PIPE_LAT-1];
    assign cap_pix = i_sram_rdata[int'(cap_tag.sub)*PIX_W +: PIX_W];

    assign push_entry = '{
        index:       cap_pix,
        transparent: (cap_pix == PIX_W'(TRANSPARENT_IDX)),
        id:          cap_tag.id
    };

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= '0;
        end else begin
            case ({accept, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    pixel_fifo #(
        .W     ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (capture),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head),
        .count    (occ),
        .empty    (fifo_empty)
    );

    assign o_pix_valid       = !fifo_empty;
    assign pop               = o_pix_valid && i_pix_ready;
    assign o_pix_index       = head.index;
    assign o_pix_transparent = head.transparent;
    assign o_pix_object_id   = head.id;

endmodule

// File: doc/sram_pixel_decoder.md
Name: sram_pixel_decoder

Overview:
- Read-side counterpart of the SRAM address encoder in the frame decoder.
- Requests (object ID, pixel index) enter the encoder and this block in the same cycle.
- This block tracks each request through the fixed address/SRAM read latency, captures the returned 16-bit word, and extracts the 4-bit palette pixel addressed by index[1:0].
- It buffers results in a credit-protected output FIFO and drives the VGA/colour stage with a valid/ready handshake.

Parameters:
- PIPE_LAT, 2, cycles from request accept to the cycle where i_sram_rdata holds that request's word (1 encoder register + 1 SRAM access); legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- DATA_W, 16, SRAM data width.
- PIX_W, 4, bits per pixel; DATA_W/PIX_W = 4 pixels per word.
- TRANSPARENT_IDX, 0, palette index treated as transparent.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  pixel request valid; same cycle as the encoder input.
- o_req_ready  out  1  request may be accepted this cycle.
- i_req_object_id  in  game_pkg::ObjectID  object being fetched.
- i_req_pixel_index  in  MAP_H_WIDTH+MAP_V_WIDTH  pixel index within the object.
- i_sram_rdata  in  DATA_W  SRAM read data.
- o_pix_valid  out  1  FIFO head valid.
- i_pix_ready  in  1  consumer accepts the head.
- o_pix_index  out  PIX_W  palette index.
- o_pix_transparent  out  1  o_pix_index == TRANSPARENT_IDX.
- o_pix_object_id  out  game_pkg::ObjectID  object tag of the head.

Behaviour:
- Reset (async, i_rst=1): tag pipeline valids, FIFO pointers, inflight counter and occupancy counter are all cleared.
  - Outputs during reset: o_pix_valid=0, o_pix_index=0, o_pix_transparent=0, o_pix_object_id=OBJECT_MAP, o_req_ready=0.
  - o_req_ready rises in the first cycle after deassertion.
- Reset mid-operation drops all inflight tags and FIFO contents; no residual output after release.
- Accept: a request is accepted when i_req_valid && o_req_ready.
- Tag pipeline: PIPE_LAT stages. Each stage holds {valid, object_id, sub=pixel_index[1:0]}. Stage 1 loads on accept; the tag advances one stage per cycle unconditionally (no stall).
- Capture: in the cycle a valid tag is in stage PIPE_LAT, i_sram_rdata belongs to that tag.
  - Pixel = i_sram_rdata[sub*PIX_W +: PIX_W] (sub 0 = bits [3:0], sub 3 = bits [15:12]).
  - {pixel, pixel==TRANSPARENT_IDX, object_id} is pushed into the FIFO at the end of that cycle.
- Latency: request accepted in cycle t appears at o_pix_valid in cycle t+PIPE_LAT+1 if the FIFO was empty. Throughput is 1 pixel/cycle while the consumer is ready.
- Credit flow control:
  - inflight = number of valid tag stages; occ = FIFO occupancy.
  - o_req_ready = !i_rst && (inflight + occ < FIFO_DEPTH), combinational from registered counts.
  - This guarantees a push never hits a full FIFO. A push to a full FIFO is an assertion failure.
- FIFO: first-word fall-through. Head outputs are driven directly from FIFO storage at the read pointer.
  - Pop on o_pix_valid && i_pix_ready.
  - Simultaneous push and pop leaves occ unchanged; pointers wrap modulo FIFO_DEPTH.
  - Push and pop on an empty FIFO in the same cycle is not a bypass: the data appears the next cycle.
- Counter updates:
  - inflight: +1 on accept, -1 on capture, unchanged when both occur.
  - occ: +1 on push, -1 on pop.
  - Both are width clog2(FIFO_DEPTH)+1.
- Stability: while o_pix_valid=1 and i_pix_ready=0, the head fields are held stable.
- Empty state: with the FIFO empty, o_pix_valid=0 and the remaining outputs hold their last value (not checked).

Decomposition:
- sram_pkg gains:
  - SRAM_DATA_W=16
  - PIXELS_PER_WORD=4
  - PIXEL_W=4
  - PIXEL_SUB_W=2
  - TRANSPARENT_IDX=0
  - SRAM_READ_PIPE_LAT=2
- The encoder and this block share SRAM_READ_PIPE_LAT so their latencies stay consistent.
- game_pkg::ObjectID is reused unchanged.
- A packed typedef PixelTag {ObjectID id; logic [1:0] sub;} goes in sram_pkg.
- Natural sub-module: pixel_fifo, a generic FWFT FIFO parameterised by width and depth with push/pop/count.

Test Plan:
- Single fetch: reset, request OBJECT_CAR1, index 0x006 (sub=2), i_sram_rdata=0xA5C3 in cycle t+2 -> cycle t+3 shows o_pix_valid=1, o_pix_index=0x5, transparent=0, object_id=OBJECT_CAR1.
- Nibble order: four back-to-back requests, sub 0..3, each returning 0x4321 -> outputs 1,2,3,4 on consecutive cycles with i_pix_ready=1.
- Transparency: word 0x00F0, sub=0 -> index 0, transparent=1; sub=1 -> index 0xF, transparent=0.
- Backpressure/credit: hold i_pix_ready=0 with i_req_valid=1 continuously -> exactly 4 requests accepted and o_req_ready=0 from then on. Raise i_pix_ready for 1 cycle -> one pop, o_req_ready=1 the next cycle, exactly one more accept. No data lost and order preserved.
- Simultaneous push/pop at occ=FIFO_DEPTH-1 with a full tag pipe -> occ stays constant, no overflow assertion, all results in order.
- Async reset with 2 tags in flight and 2 FIFO entries -> o_pix_valid falls immediately (same cycle). After release, o_req_ready=1, and no stale pixel is emitted even if i_sram_rdata toggles.
